// File: rtl/sar_search_ctrl_if.sv
// sar_search_ctrl_if: request/status handshake and comparator operand/flags
// between the SAR search controller (master) and its environment (slave).
interface sar_search_ctrl_if #(parameter int WIDTH = 4);
    logic             start;
    logic             agb;
    logic             aeb;
    logic             alb;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic             found;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (
        input  start, agb, aeb, alb,
        output trial, busy, done, found, err, result
    );

    modport slave (
        output start, agb, aeb, alb,
        input  trial, busy, done, found, err, result
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: successive-approximation search that learns a comparator's
// fixed "a" operand by driving trial values on "b" and reading agb/aeb/alb.
module sar_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    sar_search_ctrl_if.master  bus
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SEARCH, VERIFY} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic             err_q, err_d;
    logic             flags_ok;
    logic             finish;
    logic [WIDTH-1:0] decided;

    assign flags_ok = $onehot({bus.agb, bus.aeb, bus.alb});
    // VERIFY always ends; SEARCH ends early on a hit or on a bad flag set
    assign finish   = !flags_ok || bus.aeb || (state_q == VERIFY);

    always_comb begin
        decided         = trial_q;
        decided[idx_q]  = bus.agb;
        if (idx_q != '0)
            decided[idx_q - 1'b1] = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        result_d = result_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        found_d  = found_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SEARCH;
                    trial_d = {1'b1, {(WIDTH-1){1'b0}}};
                    idx_d   = IW'(WIDTH - 1);
                    busy_d  = 1'b1;
                end
            end
            SEARCH, VERIFY: begin
                if (finish) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = trial_q;
                    err_d    = !flags_ok;
                    found_d  = flags_ok && bus.aeb;
                end else if (idx_q == '0) begin
                    trial_d = decided;
                    state_d = VERIFY;
                end else begin
                    trial_d = decided;
                    idx_d   = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            result_q <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    assign bus.trial  = trial_q;
    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.found  = found_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl: directed search scenarios against a behavioural
// comparator, with an override to inject non-one-hot flag sets.
module tb_sar_search_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] target = 4'd0;
    logic       ovr = 1'b0;
    logic [2:0] ovr_f = 3'b000;
    int         total = 0;
    int         fails = 0;

    sar_search_ctrl_if #(.WIDTH(4)) bus ();

    sar_search_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.start = start;
    assign bus.agb   = ovr ? ovr_f[2] : (target > bus.trial);
    assign bus.aeb   = ovr ? ovr_f[1] : (target == bus.trial);
    assign bus.alb   = ovr ? ovr_f[0] : (target < bus.trial);

    initial forever #5 clk = ~clk;

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_done(input string tag, input logic [3:0] res, input logic fnd, input logic er);
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_result"}, 32'(bus.result), 32'(res));
        chk({tag, "_found"}, 32'(bus.found), 32'(fnd));
        chk({tag, "_err"}, 32'(bus.err), 32'(er));
    endtask

    initial begin
        #3;
        chk("rst_trial", 32'(bus.trial), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_found", 32'(bus.found), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        #9 rst_n = 1'b1;
        edge1();
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // target 9: 8,12,10,9 then hit
        target = 4'd9; start = 1'b1;
        edge1(); start = 1'b0;
        chk("t9_tr0", 32'(bus.trial), 32'd8);
        chk("t9_busy", 32'(bus.busy), 32'd1);
        edge1(); chk("t9_tr1", 32'(bus.trial), 32'd12);
        edge1(); chk("t9_tr2", 32'(bus.trial), 32'd10);
        edge1(); chk("t9_tr3", 32'(bus.trial), 32'd9);
        chk("t9_nodone", 32'(bus.done), 32'd0);
        edge1(); chk_done("t9", 4'd9, 1'b1, 1'b0);
        edge1(); chk("t9_pulse", 32'(bus.done), 32'd0);

        // target 0: 8,4,2,1,0 then VERIFY
        target = 4'd0; start = 1'b1;
        edge1(); start = 1'b0;
        chk("t0_tr0", 32'(bus.trial), 32'd8);
        edge1(); chk("t0_tr1", 32'(bus.trial), 32'd4);
        edge1(); chk("t0_tr2", 32'(bus.trial), 32'd2);
        edge1(); chk("t0_tr3", 32'(bus.trial), 32'd1);
        edge1(); chk("t0_tr4", 32'(bus.trial), 32'd0);
        chk("t0_busy", 32'(bus.busy), 32'd1);
        chk("t0_nodone", 32'(bus.done), 32'd0);
        edge1(); chk_done("t0", 4'd0, 1'b1, 1'b0);
        edge1();

        // target 15 then target 8
        target = 4'd15; start = 1'b1;
        edge1(); start = 1'b0;
        chk("t15_tr0", 32'(bus.trial), 32'd8);
        edge1(); chk("t15_tr1", 32'(bus.trial), 32'd12);
        edge1(); chk("t15_tr2", 32'(bus.trial), 32'd14);
        edge1(); chk("t15_tr3", 32'(bus.trial), 32'd15);
        edge1(); chk_done("t15", 4'd15, 1'b1, 1'b0);
        edge1();
        target = 4'd8; start = 1'b1;
        edge1(); start = 1'b0;
        chk("t8_tr0", 32'(bus.trial), 32'd8);
        edge1(); chk_done("t8", 4'd8, 1'b1, 1'b0);
        edge1();

        // invalid flags on the second trial
        target = 4'd13; start = 1'b1;
        edge1(); start = 1'b0;
        edge1(); chk("bad_tr1", 32'(bus.trial), 32'd12);
        ovr = 1'b1; ovr_f = 3'b110;
        edge1(); chk_done("bad", 4'd12, 1'b0, 1'b1);
        ovr = 1'b0;
        edge1();
        chk("bad_errdrop", 32'(bus.err), 32'd0);
        chk("bad_donedrop", 32'(bus.done), 32'd0);

        // start while busy and coincident with done is ignored
        target = 4'd9; start = 1'b1;
        edge1(); start = 1'b0;
        edge1(); chk("ign_tr1", 32'(bus.trial), 32'd12);
        start = 1'b1;
        edge1(); start = 1'b0;
        chk("ign_tr2", 32'(bus.trial), 32'd10);
        edge1(); chk("ign_tr3", 32'(bus.trial), 32'd9);
        start = 1'b1;
        edge1(); start = 1'b0;
        chk_done("ign", 4'd9, 1'b1, 1'b0);
        edge1();
        chk("ign_idle_busy", 32'(bus.busy), 32'd0);
        chk("ign_idle_trial", 32'(bus.trial), 32'd9);
        start = 1'b1;
        edge1(); start = 1'b0;
        chk("fresh_tr0", 32'(bus.trial), 32'd8);
        chk("fresh_busy", 32'(bus.busy), 32'd1);
        edge1(); edge1(); edge1();
        edge1(); chk_done("fresh", 4'd9, 1'b1, 1'b0);
        edge1();

        // start held high: one IDLE cycle between searches
        target = 4'd8; start = 1'b1;
        edge1(); chk("held_tr0", 32'(bus.trial), 32'd8);
        edge1(); chk_done("held1", 4'd8, 1'b1, 1'b0);
        edge1(); start = 1'b0;
        chk("held_rebusy", 32'(bus.busy), 32'd1);
        chk("held_retrial", 32'(bus.trial), 32'd8);
        edge1(); chk_done("held2", 4'd8, 1'b1, 1'b0);
        edge1();

        // asynchronous reset mid-search
        target = 4'd13; start = 1'b1;
        edge1(); start = 1'b0;
        edge1(); chk("ar_tr1", 32'(bus.trial), 32'd12);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_trial", 32'(bus.trial), 32'd0);
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_done", 32'(bus.done), 32'd0);
        chk("ar_result", 32'(bus.result), 32'd0);
        #2 rst_n = 1'b1;
        edge1();
        chk("ar_idle", 32'(bus.busy), 32'd0);
        chk("ar_nodone", 32'(bus.done), 32'd0);
        target = 4'd5; start = 1'b1;
        edge1(); start = 1'b0;
        chk("t5_tr0", 32'(bus.trial), 32'd8);
        edge1(); chk("t5_tr1", 32'(bus.trial), 32'd4);
        edge1(); chk("t5_tr2", 32'(bus.trial), 32'd6);
        edge1(); chk("t5_tr3", 32'(bus.trial), 32'd5);
        edge1(); chk_done("t5", 4'd5, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Sequential successive-approximation controller on the requesting side of the magnitude-comparator interface.
- Drives the trial operand (comparator input b) and consumes the agb/aeb/alb flags produced against a fixed target (comparator input a).
- Binary-searches the target's value and reports it with a found/err status.
- Sits beside the combinational comparator. Lets a block learn an operand it can only compare against, such as a threshold or a remote register.

Parameters:
- WIDTH, 4, operand width in bits. Legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a search; sampled only in IDLE
- agb  input  1  comparator flag: target > trial
- aeb  input  1  comparator flag: target == trial
- alb  input  1  comparator flag: target < trial
- trial  output  WIDTH  operand driven to the comparator b input (registered)
- busy  output  1  high in SEARCH and VERIFY
- done  output  1  one-cycle pulse when a search ends
- found  output  1  valid with done: result equals target
- err  output  1  valid with done: flags were not one-hot
- result  output  WIDTH  final value; held until the next done

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE; trial, result, bit index = 0; busy, done, found, err = 0.
- Comparator path is combinational. Flags are sampled at the clock edge after trial is registered (one trial per cycle).
- A flag set is valid when exactly one of agb/aeb/alb is high.
- IDLE:
  - start=1 loads trial = 1<<(WIDTH-1) and idx = WIDTH-1, then goes to SEARCH.
  - done and err drop to 0 one cycle after pulsing.
  - trial holds its last value.
- SEARCH, each edge:
  - Invalid flags: result = trial, err=1, found=0, done=1, go to IDLE.
  - aeb: result = trial, found=1, done=1, go to IDLE (early exit).
  - agb: keep trial[idx]. alb: clear trial[idx].
  - After agb/alb with idx>0: set trial[idx-1], idx decrements, stay in SEARCH.
  - After agb/alb with idx==0: apply the bit decision only, then go to VERIFY.
- VERIFY, one edge:
  - Invalid flags: same as SEARCH, err=1.
  - Otherwise: result = trial, found = aeb, done=1, go to IDLE.
  - Covers target 0 and any target never hit exactly in SEARCH.
- Latency, counted in edges after the start-capture edge:
  - Minimum 1 (aeb on the first trial, i.e. target = 2^(WIDTH-1)).
  - Maximum WIDTH+1.
- busy is high exactly while state is SEARCH or VERIFY. It clears on the same edge that asserts done.
- start while busy is ignored, with no restart.
- start on the same edge done asserts is also ignored, since state is not yet IDLE. A new search needs start in a later IDLE cycle.
- start held high in IDLE launches back-to-back searches, with one IDLE cycle between each.
- Reset asserted mid-search returns all outputs to reset values immediately, without waiting for a clock. No done pulse is produced.
- Width rules:
  - trial and result never exceed WIDTH bits.
  - idx is sized clog2(WIDTH).
  - No arithmetic beyond bit set/clear.

Test Plan:
- Target 9, WIDTH=4: start → trial sequence 8,12,10,9. done on the 4th edge after capture, result=9, found=1, err=0.
- Target 0: trials 8,4,2,1,0, then VERIFY with aeb=1 → done on the 5th edge, result=0, found=1.
- Target 15: trials 8,12,14,15; aeb on 15 → done on the 4th edge, result=15, found=1. Then target 8 → done on the 1st edge, result=8.
- Bench forces agb=aeb=1 on the 2nd trial → done, err=1, found=0, result=12 (for target >8 path), back to IDLE.
- Pulse start during SEARCH, and again coincident with done → no restart, trial sequence unchanged. Next start in IDLE runs a fresh search.
- Assert rst_n=0 mid-search (trial=12) between edges → trial=0, busy=0, done=0 immediately. After release, a new search of target 5 gives trials 8,4,6,5 and result=5.
